// File: rtl/uart_msg_echo_ctrl.sv
// Byte controller between uart_rx and uart_tx: periodic fixed message plus FIFO-buffered echo.
// Optional build macro UART_ECHO_UPCASE_EN: echoed 'a'..'z' are sent as 'A'..'Z'.
module uart_msg_echo_ctrl #(
  parameter int unsigned          CLK_FRE    = 27,
  parameter int unsigned          PERIOD_MS  = 1000,
  parameter int unsigned          MSG_LEN    = 7,
  parameter logic [MSG_LEN*8-1:0] MSG        = 56'h48656C6C6F0D0A,
  parameter int unsigned          FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_data_valid,
  output logic                          rx_data_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_data_ready,
  output logic                          msg_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state_dbg
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L     = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] PERIOD_LAST = 32'(CLK_FRE * 1000 * PERIOD_MS - 1);
  localparam logic [7:0]  LAST_IDX    = 8'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic [7:0]    idx_q;
  logic [31:0]   cnt_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          full, empty, push, pop, xfer, go_send;
  logic [7:0]    head, echo_byte;

  function automatic logic [7:0] msg_at(input logic [7:0] i);
    return 8'(MSG >> ((MSG_LEN - 1 - int'(i)) * 8));
  endfunction

  // tx handshake: a byte moves on every edge with tx_data_valid & tx_data_ready;
  // once valid is high, tx_data is frozen and valid stays high until that edge (reset excepted).
  assign full    = (count_q == DEPTH_L);
  assign empty   = (count_q == '0);
  assign push    = rx_data_valid && !full && (state_q != S_IDLE);
  assign xfer    = tx_valid_q && tx_data_ready;
  assign go_send = (state_q == S_WAIT) && enable && !tx_valid_q && (cnt_q >= PERIOD_LAST);
  assign pop     = (state_q == S_WAIT) && !tx_valid_q && !empty && !go_send;
  assign head    = mem_q[rd_ptr_q];

`ifdef UART_ECHO_UPCASE_EN
  assign echo_byte = (head >= 8'h61 && head <= 8'h7A) ? (head - 8'h20) : head;
`else
  assign echo_byte = head;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (rx_data_valid & full);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (enable) begin
            state_q <= S_SEND;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_SEND: begin
          if (!tx_valid_q) begin
            tx_data_q  <= msg_at(idx_q);
            tx_valid_q <= 1'b1;
          end else if (tx_data_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              tx_valid_q <= 1'b0;
              cnt_q      <= '0;
              busy_q     <= 1'b0;
              state_q    <= S_WAIT;
            end else begin
              idx_q     <= idx_q + 8'd1;
              tx_data_q <= msg_at(idx_q + 8'd1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
          // The message only takes over once no echo byte is outstanding.
          if (xfer) begin
            tx_valid_q <= 1'b0;
          end else if (go_send) begin
            state_q <= S_SEND;
            busy_q  <= 1'b1;
          end else if (pop) begin
            tx_data_q  <= echo_byte;
            tx_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          idx_q      <= '0;
          cnt_q      <= '0;
        end
      endcase
    end
  end

  assign rx_data_ready = !full;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign msg_busy      = busy_q;
  assign overflow      = overflow_q;
  assign fifo_level    = count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_msg_echo_ctrl.sv
// Bench for uart_msg_echo_ctrl: tagged expected byte stream (message vs echo) checked by a monitor.
module tb_uart_msg_echo_ctrl;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 1000;
  localparam int RM_ONE = 0, RM_TOGGLE = 1, RM_ZERO = 2, RM_RAND = 3, RM_MANUAL = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_data_valid = 1'b0;
  logic       rx_data_ready;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready = 1'b1;
  logic       msg_busy;
  logic       overflow;
  logic [2:0] fifo_level;
  logic [1:0] state_dbg;

  uart_msg_echo_ctrl #(
    .CLK_FRE(1), .PERIOD_MS(1), .MSG_LEN(7), .MSG(56'h48656C6C6F0D0A), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .msg_busy(msg_busy), .overflow(overflow), .fifo_level(fifo_level), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int         vectors = 0;
  int         miscompares = 0;
  int         msg_xfers = 0;
  int         ready_mode = RM_ONE;
  logic [8:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] msg_bytes [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_msg();
    foreach (msg_bytes[i]) exp_q.push_back({1'b1, msg_bytes[i]});
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    if (m == RM_ONE) tx_data_ready = 1'b1;
    else if (m == RM_ZERO) tx_data_ready = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int max, output int n);
    n = 0;
    while (msg_busy !== val && n < max) begin
      @(posedge clock); #1;
      n++;
    end
    vectors++;
    if (msg_busy !== val) begin
      miscompares++;
      $display("FAIL busy_timeout: msg_busy=%0b after %0d cycles, wanted %0b", msg_busy, n, val);
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clock); #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d bytes still expected, wanted 0", exp_q.size());
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the sampled rx_data_ready.
  task automatic push_byte(input logic [7:0] b, output logic accepted);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(negedge clock);
    accepted = rx_data_ready;
    @(posedge clock); #1;
    rx_data_valid = 1'b0;
  endtask

  // Monitor: every transfer pops the expected {is_message, byte}; stalls must hold data.
  always @(negedge clock) begin
    logic [8:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (tx_data_valid !== 1'b1 || tx_data !== prev_data) begin
          miscompares++;
          $display("FAIL tx_hold: got valid=%0b data=%02h expected valid=1 data=%02h",
                   tx_data_valid, tx_data, prev_data);
        end
      end
      if (tx_data_valid && tx_data_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL tx_unexpected: got busy=%0b data=%02h expected no transfer", msg_busy, tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({msg_busy, tx_data} !== e) begin
            miscompares++;
            $display("FAIL tx_byte: got busy=%0b data=%02h expected busy=%0b data=%02h",
                     msg_busy, tx_data, e[8], e[7:0]);
          end
          if (e[8]) msg_xfers++;
        end
      end
      prev_stall = tx_data_valid && !tx_data_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clock); #1;
      ph++;
      case (ready_mode)
        RM_ONE:    tx_data_ready = 1'b1;
        RM_TOGGLE: tx_data_ready = (ph % 4 == 0);
        RM_ZERO:   tx_data_ready = 1'b0;
        RM_RAND:   tx_data_ready = 1'($urandom_range(0, 1));
        default:   ;
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc, exp_rdy, pop_m;
    int         n, occ, held, tries;
    logic [7:0] b;
    logic [7:0] acc_q[$];
    logic [7:0] echo_in [3] = '{8'h41, 8'h62, 8'h63};

    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", tx_data_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", msg_busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    check("rst_rx_ready", rx_data_ready, 1);

    // First message straight after reset, then the period to the second one.
    push_msg();
    reset = 1'b0;
    wait_busy(1'b1, 10, n);
    wait_busy(1'b0, 200, n);
    push_msg();
    set_mode(RM_TOGGLE);
    wait_busy(1'b1, 2 * PERIOD, n);
    check("period_cycles", n, PERIOD);

    // Bytes arriving during SEND are echoed after the message.
    foreach (echo_in[i]) begin
      push_byte(echo_in[i], acc);
      check("push_in_send", acc, 1);
      exp_q.push_back({1'b0, echo_of(echo_in[i])});
    end
    wait_busy(1'b0, 200, n);
    wait_drain(200);
    check("level_after_echo", fifo_level, 0);
    check("no_overflow_yet", overflow, 0);

    // Fill with tx stalled: one byte parks in the tx register, DEPTH in the FIFO.
    set_mode(RM_ZERO);
    @(posedge clock); #1;
    occ = 0;
    held = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_rdy = (occ < DEPTH);
      push_byte(b, acc);
      check("rx_ready_fill", acc, exp_rdy);
      if (exp_rdy) begin
        pop_m = (held == 0 && occ > 0);
        occ   = occ + 1 - int'(pop_m);
        if (pop_m) held = 1;
        acc_q.push_back(b);
      end
    end
    check("overflow_set", overflow, 1);
    check("level_full", fifo_level, occ);
    check("rx_ready_full", rx_data_ready, 0);

    // Period expires while the echo byte is stalled: WAIT holds until it moves.
    repeat (PERIOD + 100) @(posedge clock);
    #1;
    check("stall_busy", msg_busy, 0);
    check("stall_valid", tx_data_valid, 1);
    check("stall_data", tx_data, echo_of(acc_q[0]));
    exp_q.push_back({1'b0, echo_of(acc_q.pop_front())});
    push_msg();
    while (acc_q.size() != 0) exp_q.push_back({1'b0, echo_of(acc_q.pop_front())});
    set_mode(RM_ONE);
    wait_busy(1'b1, 10, n);
    enable = 1'b0;
    wait_busy(1'b0, 100, n);
    wait_drain(100);
    check("level_drained", fifo_level, 0);
    check("overflow_sticky", overflow, 1);

    // Echo-only mode with random traffic and random back-pressure.
    set_mode(RM_RAND);
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
      b = 8'($urandom_range(0, 255));
      tries = 0;
      do begin
        push_byte(b, acc);
        tries++;
      end while (!acc && tries < 64);
      if (acc) exp_q.push_back({1'b0, echo_of(b)});
      else check("rx_ready_random", acc, 1);
    end
    wait_drain(2000);
    repeat (PERIOD + 200) @(posedge clock);
    #1;
    check("echo_only_busy", msg_busy, 0);
    check("echo_only_valid", tx_data_valid, 0);
    check("echo_only_level", fifo_level, 0);

    // Reset in the middle of a message, then a clean restart.
    set_mode(RM_MANUAL);
    tx_data_ready = 1'b1;
    enable = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst2_overflow", overflow, 0);
    check("rst2_valid", tx_data_valid, 0);
    msg_xfers = 0;
    push_msg();
    reset = 1'b0;
    n = 0;
    while (msg_xfers < 3 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("xfers_before_reset", msg_xfers, 3);
    tx_data_ready = 1'b0;
    check("idx3_valid", tx_data_valid, 1);
    check("idx3_byte", tx_data, msg_bytes[3]);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    check("mid_rst_valid", tx_data_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_busy", msg_busy, 0);
    reset = 1'b0;
    tx_data_ready = 1'b1;
    push_msg();
    wait_busy(1'b1, 10, n);
    wait_busy(1'b0, 100, n);
    wait_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
